// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate truth-table tester.
// Vector index k drives {b,a} = k; truth tables are indexed the same way.
package gate_tester_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int NUM_VECTORS = 4;
   localparam int IDX_W       = 2;
   localparam int CNT_W       = 4;

   localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
   localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
   localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
   localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;

   // Final truth table: the last vector's sample lands on the same edge
   // as the compare, so it is merged in ahead of the registered result.
   function automatic logic [NUM_VECTORS-1:0] merge_last(
      input logic [NUM_VECTORS-1:0] res,
      input logic                   y
   );
      return {y, res[NUM_VECTORS-2:0]};
   endfunction

endpackage

// File: rtl/gate_tester_settle_timer.sv
// Settle timer: counts RUN clocks and ticks on the edge that closes
// each vector's hold window of SETTLE_CYCLES clocks.
module gate_tester_settle_timer
   import gate_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   // Next count: restart on clear or tick, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_truth_tester.sv
// Drives all four {b,a} vectors into a 2-input gate, samples its output
// after a settle window and compares the captured table to EXPECTED.
module gate_truth_tester
   import gate_tester_pkg::*;
#(
   parameter int unsigned                SETTLE_CYCLES = 2,
   parameter logic [NUM_VECTORS-1:0]     EXPECTED      = TT_AND
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   dut_y,
   output logic                   dut_a,
   output logic                   dut_b,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_VECTORS-1:0] result,
   output logic [NUM_VECTORS-1:0] fail_mask
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [1:0]             drv_q, drv_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic [NUM_VECTORS-1:0] res_q, res_d;
   logic [NUM_VECTORS-1:0] fail_q, fail_d;
   logic [NUM_VECTORS-1:0] final_res;
   logic [NUM_VECTORS-1:0] final_fail;
   logic                   launch;
   logic                   running;
   logic                   tick;

   assign running    = (state_q == RUN);
   assign launch     = (state_q == IDLE) && start;
   assign final_res  = merge_last(res_q, dut_y);
   assign final_fail = final_res ^ EXPECTED;

   gate_tester_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk_i  (clk),
      .rst_i  (rst),
      .clear_i(launch),
      .en_i   (running),
      .tick_o (tick)
   );

   // Sequencer: launch, step vectors on each tick, compare on the last.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drv_d   = drv_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      res_d   = res_q;
      fail_d  = fail_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               idx_d   = '0;
               drv_d   = 2'b00;
               res_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (tick) begin
               res_d[idx_q] = dut_y;
               if (idx_q != LAST_IDX) begin
                  idx_d = idx_q + 1'b1;
                  drv_d = idx_q + 1'b1;
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
                  drv_d   = 2'b00;
                  done_d  = 1'b1;
                  fail_d  = final_fail;
                  pass_d  = (final_fail == '0);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         drv_q   <= 2'b00;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         res_q   <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drv_q   <= drv_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         res_q   <= res_d;
         fail_q  <= fail_d;
      end
   end

   assign dut_a     = drv_q[0];
   assign dut_b     = drv_q[1];
   assign busy      = running;
   assign done      = done_q;
   assign pass      = pass_q;
   assign result    = res_q;
   assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_truth_tester.sv
// Bench for gate_truth_tester: a gate model on dut_y, a per-cycle
// sequence model and a scoreboard of expected run outcomes.
module tb_gate_truth_tester;
   import gate_tester_pkg::*;

   localparam int S = 2;

   typedef struct packed {
      logic [3:0] res;
      logic [3:0] fm;
      logic       pass;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dut_y;
   logic       dut_a;
   logic       dut_b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] result;
   logic [3:0] fail_mask;
   logic       or_mode;

   int   checks;
   int   failures;
   exp_t sb[$];

   gate_truth_tester #(
      .SETTLE_CYCLES(S),
      .EXPECTED     (TT_AND)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dut_y    (dut_y),
      .dut_a    (dut_a),
      .dut_b    (dut_b),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .result   (result),
      .fail_mask(fail_mask)
   );

   assign dut_y = or_mode ? (dut_a | dut_b) : (dut_a & dut_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {done,busy,b,a} seen after edge E0+j of a run.
   function automatic logic [3:0] exp_io(input int j);
      if (j >= 0 && j < 4 * S) return {2'b01, 2'(j / S)};
      if (j == 4 * S) return 4'b1000;
      return 4'b0000;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      or_mode = 1'b0;
      #3;
      checks++;
      if ({dut_a, dut_b, busy, done, pass, result, fail_mask} !== 13'd0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=0",
                  {dut_a, dut_b, busy, done, pass, result, fail_mask});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, result} !== 6'd0) begin
         failures++;
         $display("FAIL reset_release got=%b exp=0", {busy, done, result});
      end
   endtask

   task automatic test_and();
      logic [3:0] obs;
      exp_t e;
      or_mode = 1'b0;
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{res: TT_AND, fm: 4'b0000, pass: 1'b1});
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         obs = {done, busy, dut_b, dut_a};
         checks++;
         if (obs !== exp_io(j)) begin
            failures++;
            $display("FAIL and_io j=%0d got=%b exp=%b", j, obs, exp_io(j));
         end
         if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL and_sb_empty got=done exp=none");
            end else begin
               e = sb.pop_front();
               if ({result, fail_mask, pass} !== e) begin
                  failures++;
                  $display("FAIL and_out got=%b exp=%b",
                           {result, fail_mask, pass}, e);
               end
            end
         end
      end
      checks++;
      if ({result, fail_mask, pass} !== {TT_AND, 4'b0000, 1'b1}) begin
         failures++;
         $display("FAIL and_hold got=%b exp=%b",
                  {result, fail_mask, pass}, {TT_AND, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({result, fail_mask, pass} !== 9'd0) begin
         failures++;
         $display("FAIL async_clear got=%b exp=0", {result, fail_mask, pass});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_or_fault(input bit restart_mid);
      logic [3:0] obs;
      exp_t e;
      int   ndone;
      ndone = 0;
      or_mode = 1'b1;
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{res: TT_OR, fm: 4'b0110, pass: 1'b0});
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (j == 2 && restart_mid) start = 1'b1;
         if (j == 3) start = 1'b0;
         obs = {done, busy, dut_b, dut_a};
         checks++;
         if (obs !== exp_io(j)) begin
            failures++;
            $display("FAIL or_io mid=%0d j=%0d got=%b exp=%b",
                     restart_mid, j, obs, exp_io(j));
         end
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL or_sb_empty got=done exp=none");
            end else begin
               e = sb.pop_front();
               if ({result, fail_mask, pass} !== e) begin
                  failures++;
                  $display("FAIL or_out got=%b exp=%b",
                           {result, fail_mask, pass}, e);
               end
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         failures++;
         $display("FAIL or_done_count got=%0d exp=1", ndone);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] obs;
      logic [3:0] ex;
      exp_t e;
      int   ndone;
      ndone = 0;
      or_mode = 1'b0;
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{res: TT_AND, fm: 4'b0000, pass: 1'b1});
      for (int j = 0; j < 22; j++) begin
         @(negedge clk);
         if (j == 8) begin
            or_mode = 1'b1;
            sb.push_back('{res: TT_OR, fm: 4'b0110, pass: 1'b0});
         end
         if (j == 9) start = 1'b0;
         ex = (j < 9) ? exp_io(j) : exp_io(j - 9);
         obs = {done, busy, dut_b, dut_a};
         checks++;
         if (obs !== ex) begin
            failures++;
            $display("FAIL b2b_io j=%0d got=%b exp=%b", j, obs, ex);
         end
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_sb_empty got=done exp=none");
            end else begin
               e = sb.pop_front();
               if ({result, fail_mask, pass} !== e) begin
                  failures++;
                  $display("FAIL b2b_out j=%0d got=%b exp=%b",
                           j, {result, fail_mask, pass}, e);
               end
            end
         end
      end
      checks++;
      if (ndone != 2) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d exp=2", ndone);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int   ndone;
      ndone = 0;
      or_mode = 1'b0;
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{res: TT_AND, fm: 4'b0000, pass: 1'b1});
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (j == 4) begin
            rst = 1'b1;
            #2;
            checks++;
            if ({busy, done, dut_b, dut_a} !== 4'b0000) begin
               failures++;
               $display("FAIL abort got=%b exp=0000", {busy, done, dut_b, dut_a});
            end
            rst = 1'b0;
            sb.delete();
         end
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         failures++;
         $display("FAIL abort_done got=%0d exp=0", ndone);
      end
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{res: TT_AND, fm: 4'b0000, pass: 1'b1});
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL rerun_sb_empty got=done exp=none");
            end else begin
               e = sb.pop_front();
               if ({result, fail_mask, pass} !== e) begin
                  failures++;
                  $display("FAIL rerun_out got=%b exp=%b",
                           {result, fail_mask, pass}, e);
               end
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         failures++;
         $display("FAIL rerun_done got=%0d exp=1", ndone);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_and();
      test_async_reset();
      test_or_fault(1'b0);
      test_or_fault(1'b1);
      test_back_to_back();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
